// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel button synchroniser, debouncer and
// press/release/long-press event generator; BTN_DEBOUNCE_REPEAT_EN adds auto-repeat.
module btn_debounce_multi #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 270000,
  parameter int STABLE_CNT   = 3,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] rpt
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int SW   = $clog2(STABLE_CNT + 1);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ?
                        LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [TW-1:0]    tick_cnt;
  logic             tick;

  assign raw  = btn ^ {N_BTN{~ACTIVE_HIGH}};
  assign tick = (tick_cnt == TICK_LAST);

  // two-flop synchroniser on every raw pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // shared sample-tick divider, wraps at TICK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SW-1:0] stab;
    logic [HW-1:0] hold;
    logic [1:0]    state;
    logic          lvl;
    logic          prs;
    logic          rls;
    logic          lng;
    logic          diff;
    logic          flip;
    logic          rise;
    logic          fall;

    assign diff = tick && (sync2[i] != lvl);
    assign flip = diff && (stab == STAB_LAST);
    assign rise = flip && !lvl;
    assign fall = flip && lvl;

    assign level[i]      = lvl;
    assign press[i]      = prs;
    assign rel[i]        = rls;
    assign long_press[i] = lng;

    // stability filter; edges become registered press/rel pulses
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stab <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
      end else begin
        prs <= rise;
        rls <= fall;
        if (flip) begin
          lvl  <= ~lvl;
          stab <= '0;
        end else if (diff) begin
          stab <= stab + 1'b1;
        end else if (tick) begin
          stab <= '0;
        end
      end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    logic rp;
    assign rpt[i] = rp;
`endif

    // hold-time FSM: release always beats long-press and repeat
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= S_IDLE;
        hold  <= '0;
        lng   <= 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rp    <= 1'b0;
`endif
      end else begin
        lng <= 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rp  <= 1'b0;
`endif
        unique case (state)
          S_IDLE: begin
            if (rise) begin
              state <= S_PRESSED;
              hold  <= '0;
            end
          end
          S_PRESSED: begin
            if (fall) begin
              state <= S_IDLE;
              hold  <= '0;
            end else if (tick) begin
              if (hold == LONG_LAST) begin
                lng   <= 1'b1;
                state <= S_HELD;
                hold  <= '0;
              end else begin
                hold <= hold + 1'b1;
              end
            end
          end
          S_HELD: begin
            if (fall) begin
              state <= S_IDLE;
              hold  <= '0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            end else if (tick) begin
              if (hold == REP_LAST) begin
                rp   <= 1'b1;
                hold <= '0;
              end else begin
                hold <= hold + 1'b1;
              end
`endif
            end
          end
          default: begin
            state <= S_IDLE;
            hold  <= '0;
          end
        endcase
      end
    end
  end

`ifndef BTN_DEBOUNCE_REPEAT_EN
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed bench for btn_debounce_multi,
// TICK_DIV=4, STABLE_CNT=3, LONG_TICKS=5, REPEAT_TICKS=2.
module tb_btn_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] long_press;
  logic [3:0] rpt;

  logic [3:0] btn_n;
  logic [3:0] level_n;
  logic [3:0] press_n;
  logic [3:0] rel_n;
  logic [3:0] long_n;
  logic [3:0] rpt_n;

  int total;
  int bad;
  int cyc;
  int base;

  int press_cnt [4];
  int press_at  [4];
  int rel_cnt   [4];
  int rel_at    [4];
  int long_cnt  [4];
  int long_at   [4];
  int rpt_cnt   [4];
  int rpt_first [4];
  int lvl_seen  [4];
  int p2_cnt    [4];

  btn_debounce_multi #(
    .N_BTN(4), .TICK_DIV(4), .STABLE_CNT(3),
    .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_HIGH(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .level(level), .press(press), .rel(rel),
    .long_press(long_press), .rpt(rpt)
  );

  btn_debounce_multi #(
    .N_BTN(4), .TICK_DIV(4), .STABLE_CNT(3),
    .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_HIGH(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .btn(btn_n),
    .level(level_n), .press(press_n), .rel(rel_n),
    .long_press(long_n), .rpt(rpt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge counter and pulse log, sampled 1ns after each edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        press_cnt[i] = 0; press_at[i]  = -1;
        rel_cnt[i]   = 0; rel_at[i]    = -1;
        long_cnt[i]  = 0; long_at[i]   = -1;
        rpt_cnt[i]   = 0; rpt_first[i] = -1;
        lvl_seen[i]  = 0; p2_cnt[i]    = 0;
      end else begin
        if (press[i]) begin
          press_cnt[i]++; press_at[i] = cyc;
        end
        if (rel[i]) begin
          rel_cnt[i]++; rel_at[i] = cyc;
        end
        if (long_press[i]) begin
          long_cnt[i]++; long_at[i] = cyc;
        end
        if (rpt[i]) begin
          if (rpt_cnt[i] == 0) rpt_first[i] = cyc;
          rpt_cnt[i]++;
        end
        if (level[i]) lvl_seen[i]++;
        if (press_n[i]) p2_cnt[i]++;
      end
    end
  end

  // edge at which level flips for a btn change first seen at edge e:
  // 2 sync edges, then the 3rd tick edge; ticks at (n-base)%4==0
  function automatic int exp_edge(int e);
    int f;
    f = e + 2;
    while (((f - base) % 4) != 0) f++;
    return f + 8;
  endfunction

  task automatic run_to(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({level, press, rel, long_press, rpt} !== 20'h0) begin
      bad++;
      $display("FAIL reset_out got=%h want=0",
               {level, press, rel, long_press, rpt});
    end
    total++;
    if ({level_n, press_n, rel_n, long_n, rpt_n} !== 20'h0) begin
      bad++;
      $display("FAIL reset_out_n got=%h want=0",
               {level_n, press_n, rel_n, long_n, rpt_n});
    end
    rst = 1'b1;
    base = cyc;
  endtask

  task automatic test_clean_press();
    int p;
    int r;
    do_reset();
    repeat (2) @(negedge clk);
    btn[0] = 1'b1;
    p = exp_edge(cyc + 1);
    run_to(p + 9);
    total++;
    if (press_cnt[0] !== 1 || press_at[0] !== p) begin
      bad++;
      $display("FAIL clean_press cnt=%0d at=%0d want 1 at %0d",
               press_cnt[0], press_at[0], p);
    end
    total++;
    if (level !== 4'b0001) begin
      bad++;
      $display("FAIL clean_level got=%b want=0001", level);
    end
    btn[0] = 1'b0;
    r = exp_edge(cyc + 1);
    run_to(r + 8);
    total++;
    if (rel_cnt[0] !== 1 || rel_at[0] !== r) begin
      bad++;
      $display("FAIL clean_rel cnt=%0d at=%0d want 1 at %0d",
               rel_cnt[0], rel_at[0], r);
    end
    total++;
    if (level !== 4'b0000) begin
      bad++;
      $display("FAIL clean_level_off got=%b want=0000", level);
    end
    // fall lands on p+20, the same tick as the long threshold
    total++;
    if (r !== p + 20 || long_cnt[0] !== 0) begin
      bad++;
      $display("FAIL rel_beats_long long=%0d r-p=%0d want 0,20",
               long_cnt[0], r - p);
    end
    total++;
    if (press_cnt[1] + press_cnt[2] + press_cnt[3] !== 0) begin
      bad++;
      $display("FAIL clean_other got=%0d want=0",
               press_cnt[1] + press_cnt[2] + press_cnt[3]);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      btn[1] = ~btn[1];
      repeat (5) @(negedge clk);
    end
    btn[1] = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (lvl_seen[1] !== 0) begin
      bad++;
      $display("FAIL bounce_level seen=%0d want=0", lvl_seen[1]);
    end
    total++;
    if (press_cnt[1] !== 0) begin
      bad++;
      $display("FAIL bounce_press got=%0d want=0", press_cnt[1]);
    end
    total++;
    if (rel_cnt[1] !== 0) begin
      bad++;
      $display("FAIL bounce_rel got=%0d want=0", rel_cnt[1]);
    end
  endtask

  task automatic test_long_press();
    int p;
    int l;
    int r;
    int exp_rpt;
    do_reset();
    @(negedge clk);
    btn[2] = 1'b1;
    p = exp_edge(cyc + 1);
    l = p + 20;
    run_to(l + 200);
    total++;
    if (press_at[2] !== p) begin
      bad++;
      $display("FAIL long_press_at got=%0d want=%0d", press_at[2], p);
    end
    total++;
    if (long_cnt[2] !== 1 || long_at[2] !== l) begin
      bad++;
      $display("FAIL long_fire cnt=%0d at=%0d want 1 at %0d",
               long_cnt[2], long_at[2], l);
    end
    btn[2] = 1'b0;
    r = exp_edge(cyc + 1);
    run_to(r + 20);
    exp_rpt = 0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    for (int t = l + 8; t < r; t += 8) exp_rpt++;
    total++;
    if (rpt_first[2] !== l + 8) begin
      bad++;
      $display("FAIL rpt_first got=%0d want=%0d",
               rpt_first[2], l + 8);
    end
`endif
    total++;
    if (rpt_cnt[2] !== exp_rpt) begin
      bad++;
      $display("FAIL rpt_count got=%0d want=%0d",
               rpt_cnt[2], exp_rpt);
    end
    total++;
    if (rel_cnt[2] !== 1 || rel_at[2] !== r) begin
      bad++;
      $display("FAIL long_rel cnt=%0d at=%0d want 1 at %0d",
               rel_cnt[2], rel_at[2], r);
    end
    total++;
    if (long_cnt[2] !== 1) begin
      bad++;
      $display("FAIL long_once got=%0d want=1", long_cnt[2]);
    end
  endtask

  task automatic test_concurrency();
    int p;
    do_reset();
    @(negedge clk);
    btn   = 4'b1001;
    btn_n = 4'b1110;
    p = exp_edge(cyc + 1);
    run_to(p + 4);
    total++;
    if (press_at[0] !== p || press_at[3] !== p) begin
      bad++;
      $display("FAIL conc_same at0=%0d at3=%0d want=%0d",
               press_at[0], press_at[3], p);
    end
    total++;
    if (press_cnt[1] + press_cnt[2] !== 0) begin
      bad++;
      $display("FAIL conc_other got=%0d want=0",
               press_cnt[1] + press_cnt[2]);
    end
    total++;
    if (level !== 4'b1001) begin
      bad++;
      $display("FAIL conc_level got=%b want=1001", level);
    end
    total++;
    if (p2_cnt[0] !== 1 ||
        p2_cnt[1] + p2_cnt[2] + p2_cnt[3] !== 0) begin
      bad++;
      $display("FAIL polarity_press ch0=%0d rest=%0d want 1,0",
               p2_cnt[0], p2_cnt[1] + p2_cnt[2] + p2_cnt[3]);
    end
    total++;
    if (level_n !== 4'b0001) begin
      bad++;
      $display("FAIL polarity_level got=%b want=0001", level_n);
    end
    btn   = 4'b0000;
    btn_n = 4'b1111;
  endtask

  task automatic test_async_reset();
    int p;
    do_reset();
    @(negedge clk);
    btn[2] = 1'b1;
    p = exp_edge(cyc + 1);
    run_to(p + 26);
    total++;
    if (level[2] !== 1'b1 || long_cnt[2] !== 1) begin
      bad++;
      $display("FAIL areset_pre lvl=%b long=%0d want 1,1",
               level[2], long_cnt[2]);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({level, press, rel, long_press, rpt} !== 20'h0) begin
      bad++;
      $display("FAIL areset_now got=%h want=0",
               {level, press, rel, long_press, rpt});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = cyc;
    p = exp_edge(cyc + 1);
    run_to(p + 4);
    total++;
    if (press_cnt[2] !== 1 || press_at[2] !== base + 12) begin
      bad++;
      $display("FAIL areset_requal cnt=%0d at=%0d want 1 at %0d",
               press_cnt[2], press_at[2], base + 12);
    end
    btn = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    base  = 0;
    rst   = 1'b0;
    btn   = 4'b0000;
    btn_n = 4'b1111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_concurrency();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
